uart_tx_fifo: RTL and testbench

Next-generation memory-mapped UART transmitter for the SoC IO block, replacing the single-byte busy/ready TX path. It has a parametrised FIFO, a runtime baud divisor, selectable parity and stop bits, and a selectable full-FIFO policy (stall or drop-with-flag). Firmware that polls status bit0 at offset 0x08 and then writes offset 0x04 keeps working unchanged.

---
 rtl/uart_tx_fifo_pkg.sv | 42 ++++
 rtl/uart_tx_fifo_sync.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, parity encodings and the TX FSM state type.
package uart_tx_fifo_pkg;

  // Register byte offsets within the UART window
  localparam logic [3:0] IO_UART_TX_OFFSET     = 4'h4;
  localparam logic [3:0] IO_UART_STATUS_OFFSET = 4'h8;
  localparam logic [3:0] IO_UART_CTRL_OFFSET   = 4'hC;

  // STATUS bit indices
  localparam int IO_UART_STATUS_FULL      = 0;
  localparam int IO_UART_STATUS_ACTIVE    = 1;
  localparam int IO_UART_STATUS_EMPTY     = 2;
  localparam int IO_UART_STATUS_OVERFLOW  = 3;
  localparam int IO_UART_STATUS_LEVEL_LSB = 8;

  // CTRL field positions (divisor occupies the low DIV_W bits)
  localparam int IO_UART_CTRL_PARITY_LSB = 16;
  localparam int IO_UART_CTRL_STOP2      = 18;

  // Parity encodings; 2'b11 behaves like no parity
  typedef enum logic [1:0] {
    IO_UART_PARITY_NONE  = 2'b00,
    IO_UART_PARITY_EVEN  = 2'b01,
    IO_UART_PARITY_ODD   = 2'b10,
    IO_UART_PARITY_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Word-select compare: the two byte-lane bits of the address are ignored
  function automatic logic addr_hit(input logic [3:0] addr, input logic [3:0] offset);
    return addr[3:2] == offset[3:2];
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync.sv
// Single-clock FIFO with occupancy count; shared by the TX path and a future RX path.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write
  // NOTE: the storage array has no reset; the pointers and level alone define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL registers, a TX FIFO,
// runtime baud divisor, optional parity, one or two stop bits, and either
// stall-on-full or drop-with-overflow behaviour for TXDATA writes.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int DATA_BITS     = 8,
  parameter int DIV_W         = 16,
  parameter int DEFAULT_DIV   = 867,
  parameter bit STALL_ON_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_req,
  input  logic        mmio_we,
  input  logic [3:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        uart_tx,
  output logic        irq_tx_empty
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  // ---------------- register decode ----------------
  logic sel_tx, sel_status, sel_ctrl, wr;
  logic push, drop;

  logic [DATA_BITS-1:0] fifo_dout;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full, fifo_empty, pop;

  logic [DIV_W-1:0] div_q;
  parity_e          parity_q;
  logic             stop2_q;
  logic             overflow_q;

  assign sel_tx     = addr_hit(mmio_addr, IO_UART_TX_OFFSET);
  assign sel_status = addr_hit(mmio_addr, IO_UART_STATUS_OFFSET);
  assign sel_ctrl   = addr_hit(mmio_addr, IO_UART_CTRL_OFFSET);
  assign wr         = mmio_req && mmio_we;

  // Only a stalled TXDATA write ever waits; full is registered, so ready
  // returns the cycle after a pop frees a slot.
  assign mmio_ready = !(STALL_ON_FULL && wr && sel_tx && fifo_full);
  assign push       = wr && sel_tx && mmio_ready && !fifo_full;
  assign drop       = !STALL_ON_FULL && wr && sel_tx && fifo_full;

  logic unused_bits;
  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata};

  // Configuration and sticky overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      parity_q   <= IO_UART_PARITY_NONE;
      stop2_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr && sel_ctrl) begin
        div_q    <= mmio_wdata[DIV_W-1:0];
        parity_q <= parity_e'(mmio_wdata[IO_UART_CTRL_PARITY_LSB +: 2]);
        stop2_q  <= mmio_wdata[IO_UART_CTRL_STOP2];
      end
      if (drop)
        overflow_q <= 1'b1;
      else if (wr && sel_status && mmio_wdata[IO_UART_STATUS_OVERFLOW])
        overflow_q <= 1'b0;
    end
  end

  // ---------------- TX FIFO ----------------
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mmio_wdata[DATA_BITS-1:0]),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- TX FSM ----------------
  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_en_q, stop2_lat_q;
  logic [DIV_W-1:0]     div_lat_q;
  logic                 load, bit_done;

  assign bit_done = (timer_q == div_lat_q);

  // Next-state, bit timer and pop control
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + DIV_W'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          timer_d    = '0;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          timer_d = '0;
          if (stop2_lat_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, timer and per-frame latched character/configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_lat_q <= 1'b0;
      div_lat_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      if (load) begin
        shift_q     <= fifo_dout;
        par_bit_q   <= (^fifo_dout) ^ (parity_q == IO_UART_PARITY_ODD);
        par_en_q    <= (parity_q == IO_UART_PARITY_EVEN) || (parity_q == IO_UART_PARITY_ODD);
        stop2_lat_q <= stop2_q;
        div_lat_q   <= div_q;
      end else begin
        shift_q <= shift_d;
      end
    end
  end

  // Serial line level decoded from the current state
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      ST_START:  uart_tx = 1'b0;
      ST_DATA:   uart_tx = shift_q[0];
      ST_PARITY: uart_tx = par_bit_q;
      default:   uart_tx = 1'b1;
    endcase
  end

  assign irq_tx_empty = fifo_empty && (state_q == ST_IDLE);

  // ---------------- read mux ----------------
  logic [31:0] status_word, ctrl_word;

  // Register read data; zero unless a read is in progress
  always_comb begin
    status_word = '0;
    status_word[IO_UART_STATUS_FULL]     = fifo_full;
    status_word[IO_UART_STATUS_ACTIVE]   = (state_q != ST_IDLE);
    status_word[IO_UART_STATUS_EMPTY]    = fifo_empty;
    status_word[IO_UART_STATUS_OVERFLOW] = overflow_q;
    status_word[IO_UART_STATUS_LEVEL_LSB +: 8] = 8'(fifo_level);

    ctrl_word = '0;
    ctrl_word[DIV_W-1:0]                     = div_q;
    ctrl_word[IO_UART_CTRL_PARITY_LSB +: 2] = parity_q;
    ctrl_word[IO_UART_CTRL_STOP2]            = stop2_q;

    mmio_rdata = '0;
    if (mmio_req && !mmio_we) begin
      if (sel_status)    mmio_rdata = status_word;
      else if (sel_ctrl) mmio_rdata = ctrl_word;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one stall-mode instance and one drop-mode
// instance sharing the MMIO bus; req is steered to one of them by sel.
module tb_uart_tx_fifo;

  logic        clk, rst;
  logic        req, we, sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_s, rdata_d;
  logic        ready_s, ready_d, tx_s, tx_d, irq_s, irq_d;
  logic        req_s, req_d;

  int total = 0;
  int bad   = 0;

  logic       rec_en;
  logic       rec [$];
  logic [7:0] dec [32];

  assign req_s = req && !sel;
  assign req_d = req && sel;

  uart_tx_fifo #(.STALL_ON_FULL(1'b1)) dut (
    .clk(clk), .rst(rst), .mmio_req(req_s), .mmio_we(we), .mmio_addr(addr),
    .mmio_wdata(wdata), .mmio_rdata(rdata_s), .mmio_ready(ready_s),
    .uart_tx(tx_s), .irq_tx_empty(irq_s)
  );

  uart_tx_fifo #(.STALL_ON_FULL(1'b0)) dut_drop (
    .clk(clk), .rst(rst), .mmio_req(req_d), .mmio_we(we), .mmio_addr(addr),
    .mmio_wdata(wdata), .mmio_rdata(rdata_d), .mmio_ready(ready_d),
    .uart_tx(tx_d), .irq_tx_empty(irq_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) rec.push_back(sel ? tx_d : tx_s);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [3:0] a, input logic [31:0] d, output int waited);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; waited = 0;
    #1;
    while (!(sel ? ready_d : ready_s) && waited < 400) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 400) check("ready_timeout", sel ? ready_d : ready_s, 1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic mmio_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1 d = sel ? rdata_d : rdata_s;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Record n cycles of the stall-instance line, starting now (just after an edge)
  task automatic capture(input int n, output logic [63:0] v);
    v = '0;
    for (int c = 0; c < n; c++) begin
      v[c] = tx_s;
      @(posedge clk); #1;
    end
  endtask

  // Expected waveform: slot i of a frame held for t cycles each
  function automatic logic [63:0] expand(input logic [15:0] slots, input int n, input int t);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n * t; i++) v[i] = slots[i / t];
    return v;
  endfunction

  // Decode contiguous 1-cycle-per-bit 8N1 frames from rec, starting at the first low
  task automatic decode_stream(output int nfr, output logic tail_idle);
    int s;
    s = -1; nfr = 0; tail_idle = 1'b1;
    for (int i = 0; i < rec.size(); i++) if (rec[i] == 1'b0) begin s = i; break; end
    if (s >= 0) begin
      while (nfr < 32 && s + 10 * nfr + 9 < rec.size() &&
             rec[s + 10 * nfr] == 1'b0 && rec[s + 10 * nfr + 9] == 1'b1) begin
        for (int b = 0; b < 8; b++) dec[nfr][b] = rec[s + 10 * nfr + 1 + b];
        nfr++;
      end
      for (int i = s + 10 * nfr; i < rec.size(); i++) if (rec[i] !== 1'b1) tail_idle = 1'b0;
    end
  endtask

  initial begin
    int          w, nfr;
    logic        tail, stayed;
    logic [31:0] rd;
    logic [63:0] v;

    rst = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0; rec_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ---- reset state ----
    check("reset_tx", tx_s, 1);
    check("reset_irq", irq_s, 1);
    check("reset_tx_drop", tx_d, 1);
    mmio_read(4'h8, rd); check("reset_status", rd, 32'h4);
    mmio_read(4'hC, rd); check("reset_ctrl", rd, 32'd867);
    mmio_read(4'h4, rd); check("txdata_reads_0", rd, 32'h0);
    mmio_read(4'h0, rd); check("offset0_reads_0", rd, 32'h0);

    // ---- 0x55, DIV=3, no parity ----
    mmio_write(4'hC, 32'd3, w);
    mmio_write(4'h4, 32'h55, w);
    check("n1_tx_idle", tx_s, 1);
    check("n1_irq_low", irq_s, 0);
    @(posedge clk); #1;
    capture(40, v);
    check("frame_55", v, expand(16'h02AA, 10, 4));
    check("irq_after_frame", irq_s, 1);

    // ---- odd parity, DIV=1, 0x11 -> parity bit 1 ----
    mmio_write(4'hC, 32'h0002_0001, w);
    mmio_write(4'h4, 32'h11, w);
    @(posedge clk); #1;
    capture(22, v);
    check("frame_odd_11", v, expand(16'h0622, 11, 2));

    // ---- even parity, two stop bits, back-to-back: 4 high cycles then next start ----
    mmio_write(4'hC, 32'h0005_0001, w);
    mmio_write(4'h4, 32'h11, w);
    mmio_write(4'h4, 32'h11, w);
    capture(26, v);
    check("frame_even_2stop", v, expand(16'h0C22, 13, 2));
    repeat (30) @(posedge clk); #1;

    // ---- mid-frame divisor write, then reset with 3 bytes queued ----
    mmio_write(4'hC, 32'd3, w);
    mmio_write(4'h4, 32'h0F, w);
    mmio_write(4'hC, 32'd7, w);
    capture(8, v);
    check("bit_time_unchanged", v, expand(16'h0002, 2, 4));
    mmio_write(4'h4, 32'hA1, w);
    mmio_write(4'h4, 32'hA2, w);
    mmio_write(4'h4, 32'hA3, w);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset_tx", tx_s, 1);
    mmio_read(4'h8, rd); check("midreset_status", rd, 32'h4);
    mmio_read(4'hC, rd); check("midreset_ctrl", rd, 32'd867);
    stayed = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_s !== 1'b1) stayed = 1'b0;
    end
    check("no_frames_after_reset", stayed, 1);
    check("midreset_irq", irq_s, 1);

    // ---- stall mode: fill, 17th write waits for first pop ----
    mmio_write(4'hC, 32'd20, w);
    mmio_write(4'h4, 32'hFF, w);
    mmio_write(4'hC, 32'd0, w);
    for (int k = 0; k < 16; k++) mmio_write(4'h4, 32'(k * 8'h11), w);
    mmio_read(4'h8, rd); check("stall_full_status", rd, 32'h1003);
    repeat (30) @(posedge clk); #1;
    rec_en = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'hEE; w = 0;
    #1;
    while (!ready_s && w < 400) begin @(negedge clk); #1; w++; end
    check("stall_ready_waited", w > 100, 1);
    check("stall_ready_at_start", tx_s, 0);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    repeat (200) @(posedge clk); #1;
    rec_en = 1'b0;
    decode_stream(nfr, tail);
    check("stall_frames", nfr, 17);
    for (int k = 0; k < 16; k++) check($sformatf("stall_byte%0d", k), dec[k], 8'(k * 8'h11));
    check("stall_byte16", dec[16], 8'hEE);
    check("stall_tail_idle", tail, 1);
    check("stall_irq_end", irq_s, 1);
    rec.delete();

    // ---- drop mode: 17th write accepted and discarded, overflow sticky ----
    do_reset();
    sel = 1'b1;
    mmio_write(4'hC, 32'd30, w);
    mmio_write(4'h4, 32'hFF, w);
    mmio_write(4'hC, 32'd0, w);
    for (int k = 0; k < 16; k++) mmio_write(4'h4, 32'(k * 8'h11), w);
    mmio_read(4'h8, rd); check("drop_full_status", rd, 32'h1003);
    mmio_write(4'h4, 32'hEE, w);
    check("drop_ready_immediate", w, 0);
    mmio_read(4'h8, rd); check("drop_overflow_set", rd, 32'h100B);
    mmio_write(4'h8, 32'h8, w);
    mmio_read(4'h8, rd); check("drop_overflow_clr", rd, 32'h1003);
    repeat (40) @(posedge clk); #1;
    rec_en = 1'b1;
    repeat (450) @(posedge clk); #1;
    rec_en = 1'b0;
    decode_stream(nfr, tail);
    check("drop_frames", nfr, 16);
    for (int k = 0; k < 16; k++) check($sformatf("drop_byte%0d", k), dec[k], 8'(k * 8'h11));
    check("drop_tail_idle", tail, 1);
    check("drop_irq_end", irq_d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
